// File: rtl/key_debouncer.sv
// Debounces the active-low DE0-CV push-buttons.
// Each key also gets press/release pulses and an optional auto-repeat event stream.
module key_debouncer #(
    parameter int N_KEYS               = 4,
    parameter int DEBOUNCE_CYCLES      = 1000000,
    parameter int REPEAT_DELAY_CYCLES  = 25000000,
    parameter int REPEAT_PERIOD_CYCLES = 5000000
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic [N_KEYS-1:0] keys_raw_n,
    input  logic              repeat_en,
    output logic [N_KEYS-1:0] keys_clean,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] event_pulse,
    output logic              any_pressed
);

    localparam int MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY_CYCLES) ? DEBOUNCE_CYCLES
                                                                   : REPEAT_DELAY_CYCLES;
    localparam int MAX_P = (MAX_A > REPEAT_PERIOD_CYCLES) ? MAX_A : REPEAT_PERIOD_CYCLES;
    localparam int CW    = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD_WAIT,
        REPEATING
    } rep_state_t;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        logic            s1;
        logic            s2;
        logic            clean;
        logic            press_q;
        logic            release_q;
        logic            event_q;
        logic [CW-1:0]   db_cnt;
        logic [CW-1:0]   rp_cnt;
        rep_state_t      state;
        logic            differs;
        logic            accept;
        logic            press_acc;
        logic            release_acc;
        logic            rep_fire;

        // A new level is accepted only after it has differed for DEBOUNCE_CYCLES cycles in a row.
        always_comb begin
            differs     = (s2 != clean);
            accept      = differs && (db_cnt == DB_LAST);
            press_acc   = accept && !s2;
            release_acc = accept && s2;
            rep_fire    = repeat_en && !release_acc &&
                          (((state == HOLD_WAIT) && (rp_cnt == DLY_LAST)) ||
                           ((state == REPEATING) && (rp_cnt == PER_LAST)));
        end

        always_ff @(posedge clk_clk or posedge reset_reset) begin
            if (reset_reset) begin
                s1        <= 1'b1;
                s2        <= 1'b1;
                clean     <= 1'b1;
                db_cnt    <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                event_q   <= 1'b0;
                rp_cnt    <= '0;
                state     <= IDLE;
            end else begin
                s1 <= keys_raw_n[i];
                s2 <= s1;

                if (!differs) begin
                    db_cnt <= '0;
                end else if (accept) begin
                    db_cnt <= '0;
                    clean  <= s2;
                end else begin
                    db_cnt <= db_cnt + CW'(1);
                end

                press_q   <= press_acc;
                release_q <= release_acc;
                event_q   <= press_acc | rep_fire;

                // Repeating only starts from a press seen while enabled; release always stops it.
                if (!repeat_en || release_acc) begin
                    state  <= IDLE;
                    rp_cnt <= '0;
                end else begin
                    case (state)
                        IDLE: begin
                            if (press_acc) begin
                                state  <= HOLD_WAIT;
                                rp_cnt <= '0;
                            end
                        end
                        HOLD_WAIT: begin
                            if (rp_cnt == DLY_LAST) begin
                                state  <= REPEATING;
                                rp_cnt <= '0;
                            end else begin
                                rp_cnt <= rp_cnt + CW'(1);
                            end
                        end
                        REPEATING: begin
                            if (rp_cnt == PER_LAST) begin
                                rp_cnt <= '0;
                            end else begin
                                rp_cnt <= rp_cnt + CW'(1);
                            end
                        end
                        default: begin
                            state  <= IDLE;
                            rp_cnt <= '0;
                        end
                    endcase
                end
            end
        end

        assign keys_clean[i]    = clean;
        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = release_q;
        assign event_pulse[i]   = event_q;
    end

    assign any_pressed = ~&keys_clean;

endmodule
